// File: rtl/game_pkg.sv
// Shared types and constants for the digit code game.
package game_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENTRY,
        CHECK,
        REPORT,
        DONE
    } state_e;

endpackage

// File: rtl/digit_code_checker_if.sv
// Guess-entry channel between the game controller and the code checker.
interface digit_code_checker_if;
    import game_pkg::*;

    logic   guess_valid;
    digit_t guess_digit;
    logic   guess_ready;
    logic   clear_entry;
    logic   bad_digit;

    modport master (
        output guess_valid,
        output guess_digit,
        output clear_entry,
        input  guess_ready,
        input  bad_digit
    );

    modport slave (
        input  guess_valid,
        input  guess_digit,
        input  clear_entry,
        output guess_ready,
        output bad_digit
    );

endinterface

// File: rtl/digit_scorer.sv
// Combinational bulls/cows scoring of a guess against the secret code.
module digit_scorer
    import game_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [DIGIT_W*NUM_DIGITS-1:0] secret,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] guess,
    output logic [3:0]                    bulls_c,
    output logic [3:0]                    cows_c
);

    logic [3:0] hist_s [10];
    logic [3:0] hist_g [10];
    logic [3:0] matched;
    digit_t     s_d;
    digit_t     g_d;

    // Per-value histograms; the sum of per-value minima counts all digit matches.
    always_comb begin
        bulls_c = '0;
        matched = '0;
        s_d     = '0;
        g_d     = '0;
        for (int v = 0; v < 10; v++) begin
            hist_s[v] = '0;
            hist_g[v] = '0;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s_d = secret[i*DIGIT_W +: DIGIT_W];
            g_d = guess[i*DIGIT_W +: DIGIT_W];
            if (s_d == g_d) bulls_c = bulls_c + 4'd1;
            for (int v = 0; v < 10; v++) begin
                if (s_d == 4'(v)) hist_s[v] = hist_s[v] + 4'd1;
                if (g_d == 4'(v)) hist_g[v] = hist_g[v] + 4'd1;
            end
        end
        for (int v = 0; v < 10; v++) begin
            matched = matched + ((hist_s[v] < hist_g[v]) ? hist_s[v] : hist_g[v]);
        end
        cows_c = matched - bulls_c;
    end

endmodule

// File: rtl/digit_code_checker.sv
// Captures a random secret code, accepts digit-by-digit guesses and scores
// each complete guess as bulls and cows while tracking remaining tries.
module digit_code_checker
    import game_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned MAX_TRIES   = 8,
    parameter int unsigned LOAD_STRIDE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  digit_t                        rand_digit,
    digit_code_checker_if.slave           gif,
    output logic                          busy,
    output logic                          result_valid,
    output logic [3:0]                    bulls,
    output logic [3:0]                    cows,
    output logic [3:0]                    tries_left,
    output logic                          win,
    output logic                          lose,
    output logic [DIGIT_W*NUM_DIGITS-1:0] secret
);

    localparam int unsigned CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned POS_W  = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W  = (LOAD_STRIDE > 1) ? $clog2(LOAD_STRIDE) : 1;

    state_e             state, state_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  guess;
    logic [3:0]         sc_bulls;
    logic [3:0]         sc_cows;
    logic               new_game, load_digit, take_guess, reject_guess;

    logic stride_hit, last_pos, rand_ok, guess_ok;
    assign stride_hit = (cnt == CNT_W'(LOAD_STRIDE - 1));
    assign last_pos   = (pos == POS_W'(NUM_DIGITS - 1));
    assign rand_ok    = (rand_digit <= DIGIT_MAX);
    assign guess_ok   = (gif.guess_digit <= DIGIT_MAX);

    digit_scorer #(.NUM_DIGITS(NUM_DIGITS)) u_scorer (
        .secret  (code),
        .guess   (guess),
        .bulls_c (sc_bulls),
        .cows_c  (sc_cows)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state plus position/stride counters and datapath strobes.
    always_comb begin
        state_n      = state;
        pos_n        = pos;
        cnt_n        = '0;
        new_game     = 1'b0;
        load_digit   = 1'b0;
        take_guess   = 1'b0;
        reject_guess = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = LOAD;
                    new_game = 1'b1;
                    pos_n    = '0;
                end
            end
            LOAD: begin
                if (!stride_hit) begin
                    cnt_n = cnt + CNT_W'(1);
                end else if (rand_ok) begin
                    load_digit = 1'b1;
                    if (last_pos) begin
                        state_n = ENTRY;
                        pos_n   = '0;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end
            end
            ENTRY: begin
                if (gif.clear_entry) begin
                    pos_n = '0;
                end else if (gif.guess_valid) begin
                    if (guess_ok) begin
                        take_guess = 1'b1;
                        if (last_pos) begin
                            state_n = CHECK;
                            pos_n   = '0;
                        end else begin
                            pos_n = pos + POS_W'(1);
                        end
                    end else begin
                        reject_guess = 1'b1;
                    end
                end
            end
            CHECK: state_n = REPORT;
            REPORT: begin
                pos_n = '0;
                if (bulls == 4'(NUM_DIGITS) || tries_left == 4'd0) state_n = DONE;
                else                                               state_n = ENTRY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos             <= '0;
            cnt             <= '0;
            code            <= '0;
            guess           <= '0;
            bulls           <= '0;
            cows            <= '0;
            tries_left      <= '0;
            win             <= 1'b0;
            lose            <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            secret          <= '0;
            gif.guess_ready <= 1'b0;
            gif.bad_digit   <= 1'b0;
        end else begin
            pos <= pos_n;
            cnt <= cnt_n;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (load_digit && pos == POS_W'(i)) code[i*DIGIT_W +: DIGIT_W]  <= rand_digit;
                if (take_guess && pos == POS_W'(i)) guess[i*DIGIT_W +: DIGIT_W] <= gif.guess_digit;
            end
            if (new_game) begin
                tries_left <= 4'(MAX_TRIES);
                win        <= 1'b0;
                lose       <= 1'b0;
                bulls      <= '0;
                cows       <= '0;
            end
            if (state == CHECK) begin
                bulls      <= sc_bulls;
                cows       <= sc_cows;
                tries_left <= tries_left - 4'd1;
            end
            if (state == REPORT) begin
                if (bulls == 4'(NUM_DIGITS)) win  <= 1'b1;
                else if (tries_left == 4'd0) lose <= 1'b1;
            end
            busy            <= (state_n != IDLE) && (state_n != DONE);
            result_valid    <= (state_n == REPORT);
            secret          <= (state_n == DONE) ? code : '0;
            gif.guess_ready <= (state_n == ENTRY);
            gif.bad_digit   <= reject_guess;
        end
    end

endmodule
